wb_commit_unit: RTL and testbench
=================================

# wb_commit_unit

Parametrised writeback/commit stage for the pipelined core. It holds the MEM/WB pipeline register and performs sub-word load extension. It selects the writeback source and destination register, and arbitrates the single register-file write port between the in-order pipeline and a buffered auxiliary result source (multi-cycle mult/div). A starvation counter keeps the auxiliary source from being locked out by back-to-back pipeline writes.

## Interface
- DATA_W, 32: datapath width. Legal values are 32 and 64; sub-word lanes come from bits [31:0].
- REG_W, 5: register index width.
- LINK_REG, 31: destination register when RegDst=2'b10.
- STARVE_MAX, 4: number of cycles the auxiliary entry may wait before it forces the port; legal range 1..15.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold the stage register, so no new entry is sampled.
- flush  in  1  kill the entry being sampled; takes priority over stall.
- in_valid  in  1  MEM stage holds a valid instruction.
- IR  in  32  instruction; rt=[20:16], rd=[15:11].
- PC_plus_4  in  DATA_W  link value.
- Memory_Read_Data  in  DATA_W  raw load data.
- ALU_out  in  DATA_W  ALU result; bits [1:0] also give the load byte address.
- RegWrite  in  1  instruction writes a register.
- RegDst  in  2  00 selects rt, 01 selects rd, 1x selects LINK_REG.
- MemtoReg  in  2  00 selects ALU, 01 selects memory, 1x selects PC_plus_4.
- LoadType  in  3  0 word, 1 LB, 2 LBU, 3 LH, 4 LHU; 5..7 are treated as word.
- aux_valid  in  1  auxiliary result offered.
- aux_ready  out  1  auxiliary buffer can accept a result.
- aux_reg  in  REG_W  auxiliary destination register.
- aux_data  in  DATA_W  auxiliary result.
- hold_req  out  1  stage is blocked; upstream must freeze MEM.
- WriteBackEn  out  1  register-file write enable.
- WriteBackReg  out  REG_W  write index; 0 when WriteBackEn=0.
- WriteBackData  out  DATA_W  write data; 0 when WriteBackEn=0.

## Operation
- **Stage register S** holds: valid, IR, PC_plus_4, memory data, ALU_out, RegWrite, RegDst, MemtoReg, LoadType.
  - Each edge with !hold_req:
    - flush=1: S.valid←0.
    - else stall=0: S←inputs, S.valid←in_valid.
    - else stall=1: S holds.
  - When hold_req=1, S holds regardless of stall and flush. Flush is then lost, so upstream must re-issue it.
- **Load extension**, applied only when MemtoReg=01:
  - Byte lane is ALU_out[1:0]; lane 0 = bits [7:0]; little-endian.
  - Halfword lane is ALU_out[1]: 0 selects [15:0], 1 selects [31:16].
  - LB/LH sign-extend to DATA_W. LBU/LHU zero-extend.
  - Word: for DATA_W=64, zero-extend [31:0].
- **Pipe request (pipe_req)** = S.valid & S.RegWrite & (dest≠0). Writes to register 0 are never issued.
- **Auxiliary buffer**: one entry holding full flag, reg, data, and the wait counter (wcnt, 4 bits).
  - aux_ready = !full | aux_drain_this_cycle.
  - An accept (aux_valid & aux_ready) loads the entry at the edge and sets wcnt=0.
  - An accepted aux_reg=0 is discarded; full stays 0.
- **Arbitration** for the current cycle:
  - full & wcnt==STARVE_MAX: the auxiliary entry writes and hold_req=1. S is not consumed and wins the port next cycle.
  - else pipe_req: the pipe writes. If full, wcnt increments, saturating at STARVE_MAX.
  - else full: the auxiliary entry writes.
  - else WriteBackEn=0.
- **WAW rule**: if the pipe writes register R while the buffered auxiliary entry also targets R, the auxiliary entry is dropped at that edge (full←0). The pipe instruction is younger and wins.
  - The drop makes aux_ready=1 in the same cycle.
  - A same-cycle accept of a new aux result is allowed; the new result is not dropped.
- **hold_req** is combinational. It is asserted only in the forced cycle.

## Timing
- An entry sampled at edge k drives the write port during cycle k+1 (combinational from S).
- With hold_req, the pipe write is delayed to k+2.
- An aux result accepted at edge k writes in cycle k+1 at the earliest. Worst case it writes in cycle k+1+STARVE_MAX.
- Outputs WriteBackEn, WriteBackReg, WriteBackData, and aux_ready are combinational from state.
- **Reset** (reset=0 at an edge): all S fields←0, full←0, wcnt←0.
  - Afterwards WriteBackEn=0, WriteBackReg=0, WriteBackData=0, hold_req=0, aux_ready=1.
  - Reset during a pending auxiliary entry discards it.
- stall and flush have no effect on the auxiliary buffer.

## Test plan
- **LB and LBU extension**: ALU_out=0x1002, mem=0x12AB34CD, RegDst=00, IR[20:16]=5, MemtoReg=01.
  - LB -> next cycle WriteBackEn=1, Reg=5, Data=0xFFFFFFAB.
  - Same inputs with LBU -> Data=0x000000AB.
- **LH with upper lane**: ALU_out[1]=1, mem=0x8001_7FFF -> Data=0xFFFF8001.
- **Link write**: RegDst=10, MemtoReg=10, PC_plus_4=0x00400010 -> Reg=31, Data=0x00400010.
- **Starvation, STARVE_MAX=2**: accept aux (reg 9, data 0xDEAD) while pipe writes every cycle.
  - Required sequence: pipe writes twice, then cycle 3 writes aux with hold_req=1, then the held pipe entry writes in cycle 4.
  - aux_ready=0 from the accept edge until cycle 3.
- **WAW drop**: buffered aux targets reg 8 and the pipe writes reg 8 -> aux entry is never written; full=0 after the edge.
- **Reset and flush interaction**:
  - reset=0 with full=1 and S.valid=1 -> all outputs 0, aux_ready=1.
  - flush=1 with stall=1 -> S.valid=0, so the next cycle has no pipe write.

Source files
------------

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: MEM/WB register, sub-word load extension, and
// arbitration of the register-file write port between the pipe and a one-entry auxiliary buffer.
module wb_commit_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int LINK_REG   = 31,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [31:0]       IR,
   input  logic [DATA_W-1:0] PC_plus_4,
   input  logic [DATA_W-1:0] Memory_Read_Data,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic              RegWrite,
   input  logic [1:0]        RegDst,
   input  logic [1:0]        MemtoReg,
   input  logic [2:0]        LoadType,
   input  logic              aux_valid,
   output logic              aux_ready,
   input  logic [REG_W-1:0]  aux_reg,
   input  logic [DATA_W-1:0] aux_data,
   output logic              hold_req,
   output logic              WriteBackEn,
   output logic [REG_W-1:0]  WriteBackReg,
   output logic [DATA_W-1:0] WriteBackData
);

   localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);
   localparam logic [3:0]       WCNT_MAX = 4'(STARVE_MAX);

   typedef struct packed {
      logic              valid;
      logic [31:0]       ir;
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] mem;
      logic [DATA_W-1:0] alu;
      logic              reg_write;
      logic [1:0]        reg_dst;
      logic [1:0]        mem_to_reg;
      logic [2:0]        load_type;
   } stage_t;

   stage_t              s_q, s_in;
   logic                full_q;
   logic [REG_W-1:0]    a_reg_q;
   logic [DATA_W-1:0]   a_data_q;
   logic [3:0]          wcnt_q;

   logic [REG_W-1:0]    dest;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [DATA_W-1:0]   ld_ext;
   logic [DATA_W-1:0]   pipe_data;
   logic                pipe_req;
   logic                force_aux;
   logic                aux_drain;
   logic                aux_accept;

   always_comb begin
      s_in            = '0;
      s_in.valid      = in_valid;
      s_in.ir         = IR;
      s_in.pc4        = PC_plus_4;
      s_in.mem        = Memory_Read_Data;
      s_in.alu        = ALU_out;
      s_in.reg_write  = RegWrite;
      s_in.reg_dst    = RegDst;
      s_in.mem_to_reg = MemtoReg;
      s_in.load_type  = LoadType;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      dest = REG_W'(s_q.ir[20:16]);
      if (s_q.reg_dst[1])      dest = LINK_IDX;
      else if (s_q.reg_dst[0]) dest = REG_W'(s_q.ir[15:11]);
   end

   // Lanes always come from the low word, whatever the datapath width.
   always_comb begin
      ld_byte = s_q.mem[7:0];
      case (s_q.alu[1:0])
         2'd1:    ld_byte = s_q.mem[15:8];
         2'd2:    ld_byte = s_q.mem[23:16];
         2'd3:    ld_byte = s_q.mem[31:24];
         default: ld_byte = s_q.mem[7:0];
      endcase
      ld_half = s_q.alu[1] ? s_q.mem[31:16] : s_q.mem[15:0];
      case (s_q.load_type)
         3'd1:    ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         3'd2:    ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
         3'd3:    ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
         3'd4:    ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
         default: ld_ext = DATA_W'(s_q.mem[31:0]);
      endcase
   end

   always_comb begin
      pipe_data = s_q.alu;
      if (s_q.mem_to_reg[1])      pipe_data = s_q.pc4;
      else if (s_q.mem_to_reg[0]) pipe_data = ld_ext;
   end

   assign pipe_req  = s_q.valid && s_q.reg_write && (dest != '0);
   assign force_aux = full_q && (wcnt_q == WCNT_MAX);

   always_comb begin
      WriteBackEn   = 1'b0;
      WriteBackReg  = '0;
      WriteBackData = '0;
      hold_req      = 1'b0;
      aux_drain     = 1'b0;
      if (force_aux) begin
         WriteBackEn   = 1'b1;
         WriteBackReg  = a_reg_q;
         WriteBackData = a_data_q;
         hold_req      = 1'b1;
         aux_drain     = 1'b1;
      end else if (pipe_req) begin
         WriteBackEn   = 1'b1;
         WriteBackReg  = dest;
         WriteBackData = pipe_data;
         // The younger pipe write to the same register makes the buffered result dead.
         aux_drain     = full_q && (a_reg_q == dest);
      end else if (full_q) begin
         WriteBackEn   = 1'b1;
         WriteBackReg  = a_reg_q;
         WriteBackData = a_data_q;
         aux_drain     = 1'b1;
      end
   end

   assign aux_ready  = !full_q || aux_drain;
   assign aux_accept = aux_valid && aux_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the buffer payload is reset too; it is a handful of flops, not a RAM, and clearing it keeps outputs deterministic.
         s_q      <= '0;
         full_q   <= 1'b0;
         a_reg_q  <= '0;
         a_data_q <= '0;
         wcnt_q   <= '0;
      end else begin
         if (!hold_req) begin
            if (flush)       s_q.valid <= 1'b0;
            else if (!stall) s_q       <= s_in;
         end
         if (aux_accept) begin
            full_q   <= (aux_reg != '0);
            a_reg_q  <= aux_reg;
            a_data_q <= aux_data;
            wcnt_q   <= '0;
         end else if (aux_drain) begin
            full_q   <= 1'b0;
         end else if (full_q && pipe_req && (wcnt_q != WCNT_MAX)) begin
            wcnt_q   <= wcnt_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: table of single-cycle writeback vectors
// followed by hand-written reset, starvation, WAW and discard sequences.
module tb_wb_commit_unit;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid;
   logic [31:0] ir, pc4, mem_rd, alu_out;
   logic        reg_write;
   logic [1:0]  reg_dst, mem_to_reg;
   logic [2:0]  load_type;
   logic        aux_valid, aux_ready;
   logic [4:0]  aux_reg;
   logic [31:0] aux_data;
   logic        hold_req, wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_fail   = 0;

   wb_commit_unit #(.DATA_W(32), .REG_W(5), .LINK_REG(31), .STARVE_MAX(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .IR(ir), .PC_plus_4(pc4), .Memory_Read_Data(mem_rd), .ALU_out(alu_out),
      .RegWrite(reg_write), .RegDst(reg_dst), .MemtoReg(mem_to_reg), .LoadType(load_type),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
      .hold_req(hold_req), .WriteBackEn(wb_en), .WriteBackReg(wb_reg), .WriteBackData(wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        fl, st, iv, rw;
      logic [1:0]  rdst, mtr;
      logic [2:0]  lt;
      logic [31:0] ir, pc4, mem, alu;
      logic        en;
      logic [4:0]  wr;
      logic [31:0] wd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic fl, st, iv, rw, input logic [1:0] rdst, mtr,
                               input logic [2:0] lt, input logic [31:0] i, p, m, a,
                               input logic en, input logic [4:0] wr, input logic [31:0] wd);
      vec_t v;
      v.fl = fl; v.st = st; v.iv = iv; v.rw = rw; v.rdst = rdst; v.mtr = mtr; v.lt = lt;
      v.ir = i; v.pc4 = p; v.mem = m; v.alu = a; v.en = en; v.wr = wr; v.wd = wd;
      return v;
   endfunction

   function automatic logic [31:0] f_rt(input int r);
      return 32'(r) << 16;
   endfunction

   function automatic logic [31:0] f_rd(input int r);
      return 32'(r) << 11;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input string tag, input logic en, input logic [4:0] r,
                            input logic [31:0] d, input logic hold, input logic rdy);
      check({tag, "_en"},    32'(wb_en),     32'(en));
      check({tag, "_reg"},   32'(wb_reg),    32'(r));
      check({tag, "_data"},  wb_data,        d);
      check({tag, "_hold"},  32'(hold_req),  32'(hold));
      check({tag, "_ready"}, 32'(aux_ready), 32'(rdy));
   endtask

   task automatic drive_pipe(input logic iv, rw, input logic [1:0] rdst, mtr,
                             input logic [2:0] lt, input logic [31:0] i, p, m, a);
      in_valid = iv; reg_write = rw; reg_dst = rdst; mem_to_reg = mtr; load_type = lt;
      ir = i; pc4 = p; mem_rd = m; alu_out = a;
   endtask

   task automatic offer_aux(input logic v, input logic [4:0] r, input logic [31:0] d);
      aux_valid = v; aux_reg = r; aux_data = d;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      drive_pipe(1'b0, 1'b0, 2'b00, 2'b00, 3'd0, '0, '0, '0, '0);
      offer_aux(1'b0, '0, '0);

      // Vector table: sampled at one edge, expected on the write port the next cycle.
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd1, f_rt(5), 0, 32'h12AB34CD, 32'h1002, 1, 5, 32'hFFFFFFAB));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd2, f_rt(5), 0, 32'h12AB34CD, 32'h1002, 1, 5, 32'h000000AB));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd3, f_rt(5), 0, 32'h80017FFF, 32'h1002, 1, 5, 32'hFFFF8001));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd4, f_rt(5), 0, 32'h80017FFF, 32'h1002, 1, 5, 32'h00008001));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd3, f_rt(5), 0, 32'h80017FFF, 32'h1000, 1, 5, 32'h00007FFF));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd1, f_rt(5), 0, 32'h12AB34CD, 32'h1000, 1, 5, 32'hFFFFFFCD));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd2, f_rt(5), 0, 32'h12AB34CD, 32'h1003, 1, 5, 32'h00000012));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd0, f_rt(5), 0, 32'h12AB34CD, 32'h1001, 1, 5, 32'h12AB34CD));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b01,3'd6, f_rt(5), 0, 32'h12AB34CD, 32'h1001, 1, 5, 32'h12AB34CD));
      vecs.push_back(mk(0,0,1,1,2'b01,2'b00,3'd1, f_rd(7), 0, 32'h12AB34CD, 32'hCAFEF00D, 1, 7, 32'hCAFEF00D));
      vecs.push_back(mk(0,0,1,1,2'b10,2'b10,3'd0, f_rt(5)|f_rd(7), 32'h00400010, 0, 32'h9, 1, 31, 32'h00400010));
      vecs.push_back(mk(0,0,1,1,2'b11,2'b11,3'd0, f_rt(5)|f_rd(7), 32'h00400020, 0, 32'h9, 1, 31, 32'h00400020));
      vecs.push_back(mk(0,0,1,1,2'b00,2'b00,3'd0, f_rd(7), 0, 0, 32'h5, 0, 0, 32'h0));
      vecs.push_back(mk(0,0,1,0,2'b01,2'b00,3'd0, f_rd(7), 0, 0, 32'h5, 0, 0, 32'h0));
      vecs.push_back(mk(0,0,0,1,2'b01,2'b00,3'd0, f_rd(7), 0, 0, 32'h5, 0, 0, 32'h0));
      vecs.push_back(mk(0,0,1,1,2'b01,2'b00,3'd0, f_rd(7), 0, 0, 32'h11111111, 1, 7, 32'h11111111));
      vecs.push_back(mk(0,1,1,1,2'b01,2'b00,3'd0, f_rd(20), 0, 0, 32'h22222222, 1, 7, 32'h11111111));
      vecs.push_back(mk(1,1,1,1,2'b01,2'b00,3'd0, f_rd(20), 0, 0, 32'h22222222, 0, 0, 32'h0));
      vecs.push_back(mk(0,0,1,1,2'b01,2'b00,3'd0, f_rd(7), 0, 0, 32'h33, 1, 7, 32'h33));
      vecs.push_back(mk(1,0,1,1,2'b01,2'b00,3'd0, f_rd(20), 0, 0, 32'h44, 0, 0, 32'h0));

      tick();
      tick();
      expect_wb("reset_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      reset = 1'b1;

      foreach (vecs[i]) begin
         flush = vecs[i].fl;
         stall = vecs[i].st;
         drive_pipe(vecs[i].iv, vecs[i].rw, vecs[i].rdst, vecs[i].mtr, vecs[i].lt,
                    vecs[i].ir, vecs[i].pc4, vecs[i].mem, vecs[i].alu);
         tick();
         expect_wb($sformatf("vec%0d", i), vecs[i].en, vecs[i].wr, vecs[i].wd, 1'b0, 1'b1);
      end
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      tick();

      // Reset while both the stage register and the aux buffer hold live entries.
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(3), 0, 0, 32'h33);
      offer_aux(1'b1, 5'd9, 32'h99);
      tick();
      offer_aux(1'b0, '0, '0);
      expect_wb("rst_pre", 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      expect_wb("rst_hit", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      expect_wb("rst_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

      // Starvation with STARVE_MAX=2: two pipe writes, forced aux write, then the held entry.
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(10), 0, 0, 32'hA0);
      offer_aux(1'b1, 5'd9, 32'hDEAD);
      tick();
      offer_aux(1'b0, '0, '0);
      expect_wb("starve_c1", 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0);
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(11), 0, 0, 32'hA1);
      tick();
      expect_wb("starve_c2", 1'b1, 5'd11, 32'hA1, 1'b0, 1'b0);
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(12), 0, 0, 32'hA2);
      tick();
      expect_wb("starve_c3", 1'b1, 5'd9, 32'hDEAD, 1'b1, 1'b1);
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(13), 0, 0, 32'hA3);
      tick();
      expect_wb("starve_c4", 1'b1, 5'd12, 32'hA2, 1'b0, 1'b1);
      tick();
      expect_wb("starve_c5", 1'b1, 5'd13, 32'hA3, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick();
      expect_wb("starve_c6", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

      // WAW: pipe write to reg 8 kills the buffered result for reg 8.
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(8), 0, 0, 32'h88);
      offer_aux(1'b1, 5'd8, 32'hBEEF);
      tick();
      offer_aux(1'b0, '0, '0);
      in_valid = 1'b0;
      expect_wb("waw_pipe", 1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
      tick();
      expect_wb("waw_gone", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

      // WAW drop with a same-cycle accept: the new result must survive.
      drive_pipe(1'b1, 1'b1, 2'b01, 2'b00, 3'd0, f_rd(8), 0, 0, 32'h88);
      offer_aux(1'b1, 5'd8, 32'hBEEF);
      tick();
      offer_aux(1'b1, 5'd4, 32'h44);
      in_valid = 1'b0;
      expect_wb("waw2_pipe", 1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
      tick();
      offer_aux(1'b0, '0, '0);
      expect_wb("waw2_new", 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
      tick();
      expect_wb("waw2_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

      // Aux result aimed at register 0 is discarded on accept.
      offer_aux(1'b1, 5'd0, 32'h77);
      tick();
      offer_aux(1'b0, '0, '0);
      expect_wb("aux_r0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
